npc_ras_unit: RTL and testbench
===============================

Name: npc_ras_unit

Overview:
- Fetch-stage PC register plus next-PC selection, with a parametrised return-address stack (RAS).
- Generalises the combinational next-PC mux:
  - owns the PC register (stall-aware);
  - configurable width and reset vector;
  - adds a RAS so `jr $ra` returns can take a stacked target.
- Sits between the decode-stage control/forwarding logic and the IM address port.

Parameters:
- WIDTH, 32, PC/data width (≥ 30)
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥ 2)
- RESET_PC, 32'h0000_3000, PC value after reset (truncated to WIDTH)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  1 = hold PC and RAS (freeze fetch)
- npc_sel  in  3  next-PC select, encoding below
- instr_d  in  32  decode-stage instruction (imm16 = [15:0], index26 = [25:0])
- pc4_d  in  WIDTH  PC+4 of the decode-stage instruction
- rs_data  in  WIDTH  forwarded GPR[rs] (jr/jalr target)
- rd_data  in  WIDTH  forwarded GPR[rd] (bgeal offset)
- ras_push  in  1  decode-stage instruction is jal/jalr
- pc  out  WIDTH  current fetch PC
- pc_plus4  out  WIDTH  pc + 4
- npc  out  WIDTH  selected next PC (combinational)
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_underflow  out  1  1-cycle pulse: pop with empty RAS
- ras_miss  out  1  1-cycle pulse: RAS target ≠ rs_data (see Optional Feature)

Behaviour:
- Reset (reset_n = 0 at a rising edge; synchronous, active-low):
  - pc = RESET_PC; all RAS entries = 0; ras_count = 0;
  - ras_underflow = 0; ras_miss = 0;
  - reset overrides stall, push and pop in the same cycle.
- npc (combinational), modulo 2^WIDTH:
  - 000: pc + 4
  - 001: pc4_d + (sext(imm16) << 2) (taken branch)
  - 010: {pc4_d[WIDTH-1:28], index26, 2'b00} (j/jal)
  - 011: rs_data (jr/jalr)
  - 100: pc4_d + rd_data (bgeal)
  - 101: RAS-return target, rules below
  - 110, 111: pc + 4
- PC register:
  - every rising edge with stall = 0: pc <= npc;
  - stall = 1: pc holds;
  - latency 1 cycle; pc_plus4 is combinational from pc.
- RAS (circular buffer with top pointer), updated only when stall = 0:
  - push (ras_push = 1): entry <= pc4_d + 4 (return address past the delay slot); top advances; ras_count += 1, saturating at RAS_DEPTH.
  - Full push: overwrites the oldest entry (wrap-around); ras_count stays RAS_DEPTH.
  - pop (npc_sel = 101, non-empty): target = top entry; top retreats; ras_count -= 1.
  - Empty pop: target = rs_data; ras_count stays 0; ras_underflow = 1 for one cycle.
  - Simultaneous push and pop: top entry is replaced by the new return address; ras_count unchanged (empty case: becomes 1, underflow still pulses).
- Registered pulses: ras_underflow and ras_miss are registered and high exactly one cycle after the triggering edge; otherwise 0.
- While stall = 1:
  - no push or pop, no pulses;
  - npc still reflects inputs, using the RAS top.

Optional Feature:
- Macro: NPC_RAS_CHECK_EN.
- Defined, on non-empty pop:
  - if RAS top ≠ rs_data, the target is rs_data (architecturally correct) and ras_miss pulses;
  - the pop still occurs.
- Undefined:
  - non-empty pop target is the RAS top unconditionally;
  - ras_miss is tied to 0;
  - no comparator is built.

Test Plan:
- Reset, then release with stall = 0, npc_sel = 000 → pc = 0x3000, 0x3004, 0x3008 on successive edges; ras_count = 0.
- pc4_d = 0x3010, imm16 = 0xFFFE, npc_sel = 001 → npc = 0x3008; pc = 0x3008 after the edge.
- npc_sel = 010, instr_d = 0x0C000C10, ras_push = 1, pc4_d = 0x3020 → pc = 0x3040; ras_count = 1. Then npc_sel = 101, rs_data = 0x3024 → pc = 0x3024; ras_count = 0; ras_miss = 0.
- RAS_DEPTH = 4: five pushes (return addresses A1..A5), then five pops → targets A5, A4, A3, A2, then rs_data with a ras_underflow pulse; ras_count goes 4→0 and stays 0.
- stall = 1 for 3 cycles with npc_sel = 101 and ras_push = 1 → pc and ras_count unchanged; no pulses. Then assert reset_n = 0 with stall = 1 → pc = 0x3000; ras_count = 0.
- NPC_RAS_CHECK_EN defined: push (return address 0x3028), then pop with rs_data = 0x4000 → pc = 0x4000 and ras_miss pulses. Undefined: same stimulus → pc = 0x3028; ras_miss = 0.

Source files
------------

// File: rtl/npc_ras_unit.sv
// npc_ras_unit: fetch-stage PC register, next-PC select and a circular
// return-address stack (RAS) for jal/jalr -> jr $ra pairs.
// Optional macro NPC_RAS_CHECK_EN: compare the stacked return address with
// the forwarded rs_data on every non-empty pop. On a mismatch, take rs_data
// and pulse ras_miss. With the macro undefined, ras_miss is tied to 0 and no
// comparator is built.
module npc_ras_unit #(
    parameter int          WIDTH     = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic [2:0]                   npc_sel,
    input  logic [31:0]                  instr_d,
    input  logic [WIDTH-1:0]             pc4_d,
    input  logic [WIDTH-1:0]             rs_data,
    input  logic [WIDTH-1:0]             rd_data,
    input  logic                         ras_push,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_plus4,
    output logic [WIDTH-1:0]             npc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow,
    output logic                         ras_miss
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] LP_RESET_PC = WIDTH'(RESET_PC);
    localparam logic [CNT_W-1:0] LP_FULL     = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'b000,
        SEL_BR    = 3'b001,
        SEL_J     = 3'b010,
        SEL_JR    = 3'b011,
        SEL_BGEAL = 3'b100,
        SEL_RAS   = 3'b101
    } npc_sel_e;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_underflow;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_ret_addr;
    logic [WIDTH-1:0] w_top_entry;
    logic [WIDTH-1:0] w_ras_target;
    logic [WIDTH-1:0] w_npc;
    logic [PTR_W-1:0] w_top_inc;
    logic             w_empty;
    logic             w_pop;
    logic             w_mismatch;
    logic             w_unused_instr;

    assign w_pc_plus4  = r_pc + WIDTH'(4);
    assign w_br_off    = {{(WIDTH-18){instr_d[15]}}, instr_d[15:0], 2'b00};
    // The return address skips the delay slot, hence the extra +4 over pc4_d.
    assign w_ret_addr  = pc4_d + WIDTH'(4);
    assign w_top_entry = r_stack[r_top];
    assign w_top_inc   = r_top + PTR_W'(1);
    assign w_empty     = (r_count == '0);
    assign w_pop       = (npc_sel == SEL_RAS);
    assign w_unused_instr = &{1'b0, instr_d[31:26]};

    // Pick the RAS-return target: an empty stack falls back to rs_data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_mismatch   = 1'b0;
        w_ras_target = w_top_entry;
`ifdef NPC_RAS_CHECK_EN
        w_mismatch = (w_top_entry != rs_data);
        if (w_empty || w_mismatch) begin
            w_ras_target = rs_data;
        end
`else
        if (w_empty) begin
            w_ras_target = rs_data;
        end
`endif
    end

    // Next-PC multiplexer; reserved encodings fall through to sequential fetch.
    always_comb begin
        w_npc = w_pc_plus4;
        case (npc_sel)
            SEL_SEQ:   w_npc = w_pc_plus4;
            SEL_BR:    w_npc = pc4_d + w_br_off;
            SEL_J:     w_npc = {pc4_d[WIDTH-1:28], instr_d[25:0], 2'b00};
            SEL_JR:    w_npc = rs_data;
            SEL_BGEAL: w_npc = pc4_d + rd_data;
            SEL_RAS:   w_npc = w_ras_target;
            default:   w_npc = w_pc_plus4;
        endcase
    end

    // PC register and RAS state; everything freezes while stall is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc        <= LP_RESET_PC;
            r_top       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            // NOTE: the stack entries are reset explicitly because the reset state must be all-zero, not just "count = 0".
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_underflow <= 1'b0;
            if (!stall) begin
                r_pc        <= w_npc;
                r_underflow <= w_pop && w_empty;
                if (ras_push && w_pop && !w_empty) begin
                    // Call and return together: swap the top entry in place.
                    r_stack[r_top] <= w_ret_addr;
                end else if (ras_push) begin
                    // A full stack wraps onto its oldest entry.
                    r_stack[w_top_inc] <= w_ret_addr;
                    r_top              <= w_top_inc;
                    if (r_count != LP_FULL) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end else if (w_pop && !w_empty) begin
                    r_top   <= r_top - PTR_W'(1);
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

`ifdef NPC_RAS_CHECK_EN
    logic r_miss;

    // Registered mispredict pulse for a non-empty pop whose stacked target was wrong.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_miss <= 1'b0;
        end else begin
            r_miss <= !stall && w_pop && !w_empty && w_mismatch;
        end
    end

    assign ras_miss = r_miss;
`else
    logic w_unused_mismatch;
    assign w_unused_mismatch = w_mismatch;
    assign ras_miss          = 1'b0;
`endif

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign npc           = w_npc;
    assign ras_count     = r_count;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Self-checking bench for npc_ras_unit (default parameters). Expected values
// for pops depend on whether NPC_RAS_CHECK_EN is defined.
module tb_npc_ras_unit;

`ifdef NPC_RAS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [2:0]  npc_sel;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic [31:0] rs_data;
    logic [31:0] rd_data;
    logic        ras_push;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic [2:0]  ras_count;
    logic        ras_underflow;
    logic        ras_miss;

    int n_checks = 0;
    int n_fail   = 0;

    npc_ras_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .npc_sel       (npc_sel),
        .instr_d       (instr_d),
        .pc4_d         (pc4_d),
        .rs_data       (rs_data),
        .rd_data       (rd_data),
        .ras_push      (ras_push),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .npc           (npc),
        .ras_count     (ras_count),
        .ras_underflow (ras_underflow),
        .ras_miss      (ras_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] rs;
        logic [31:0] rd;
        logic        push;
        logic [31:0] exp_npc;
        logic [31:0] exp_pc;
        int          exp_cnt;
        logic        exp_uf;
        logic        exp_miss;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] sel, input logic [31:0] instr, input logic [31:0] p4,
                       input logic [31:0] rs, input logic [31:0] rd, input logic push,
                       input logic [31:0] e_npc, input int e_cnt, input logic e_uf,
                       input logic e_miss);
        vec_t v;
        v.sel = sel; v.instr = instr; v.pc4 = p4; v.rs = rs; v.rd = rd; v.push = push;
        v.exp_npc = e_npc; v.exp_pc = e_npc; v.exp_cnt = e_cnt;
        v.exp_uf = e_uf; v.exp_miss = e_miss;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] instr, input logic [31:0] p4,
                         input logic [31:0] rs, input logic [31:0] rd, input logic push);
        npc_sel = sel; instr_d = instr; pc4_d = p4; rs_data = rs; rd_data = rd; ras_push = push;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input int e_cnt,
                               input logic e_uf, input logic e_miss);
        check({tag, " pc"}, pc, e_pc);
        check({tag, " ras_count"}, {29'd0, ras_count}, e_cnt);
        check({tag, " ras_underflow"}, {31'd0, ras_underflow}, {31'd0, e_uf});
        check({tag, " ras_miss"}, {31'd0, ras_miss}, {31'd0, e_miss});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc_hold;

        // Sequential fetch, branches, jumps, then the RAS scenarios.
        add(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3004, 0, 1'b0, 1'b0);
        add(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3008, 0, 1'b0, 1'b0);
        add(3'd1, 32'h0000_FFFE, 32'h3010, 32'h0, 32'h0, 1'b0, 32'h3008, 0, 1'b0, 1'b0);
        add(3'd2, 32'h0C00_0C10, 32'h3020, 32'h0, 32'h0, 1'b1, 32'h3040, 1, 1'b0, 1'b0);
        add(3'd5, 32'h0, 32'h0, 32'h3024, 32'h0, 1'b0, 32'h3024, 0, 1'b0, 1'b0);
        add(3'd3, 32'h0, 32'h0, 32'h4100, 32'h0, 1'b0, 32'h4100, 0, 1'b0, 1'b0);
        add(3'd4, 32'h0, 32'h4000, 32'h0, 32'hFFFF_FF00, 1'b0, 32'h3F00, 0, 1'b0, 1'b0);
        add(3'd6, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3F04, 0, 1'b0, 1'b0);
        add(3'd7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3F08, 0, 1'b0, 1'b0);
        add(3'd2, 32'h0000_0400, 32'hA000_0010, 32'h0, 32'h0, 1'b0, 32'hA000_1000, 0, 1'b0, 1'b0);
        add(3'd1, 32'h0000_0010, 32'h3000, 32'h0, 32'h0, 1'b0, 32'h3040, 0, 1'b0, 1'b0);
        // Five pushes into a 4-deep stack: the fifth overwrites 0x3104.
        add(3'd0, 32'h0, 32'h3100, 32'h0, 32'h0, 1'b1, 32'h3044, 1, 1'b0, 1'b0);
        add(3'd0, 32'h0, 32'h3200, 32'h0, 32'h0, 1'b1, 32'h3048, 2, 1'b0, 1'b0);
        add(3'd0, 32'h0, 32'h3300, 32'h0, 32'h0, 1'b1, 32'h304C, 3, 1'b0, 1'b0);
        add(3'd0, 32'h0, 32'h3400, 32'h0, 32'h0, 1'b1, 32'h3050, 4, 1'b0, 1'b0);
        add(3'd0, 32'h0, 32'h3500, 32'h0, 32'h0, 1'b1, 32'h3054, 4, 1'b0, 1'b0);
        // Five pops with a deliberately different rs_data.
        add(3'd5, 32'h0, 32'h0, 32'h7770, 32'h0, 1'b0, CHK ? 32'h7770 : 32'h3504, 3, 1'b0, CHK);
        add(3'd5, 32'h0, 32'h0, 32'h7770, 32'h0, 1'b0, CHK ? 32'h7770 : 32'h3404, 2, 1'b0, CHK);
        add(3'd5, 32'h0, 32'h0, 32'h7770, 32'h0, 1'b0, CHK ? 32'h7770 : 32'h3304, 1, 1'b0, CHK);
        add(3'd5, 32'h0, 32'h0, 32'h7770, 32'h0, 1'b0, CHK ? 32'h7770 : 32'h3204, 0, 1'b0, CHK);
        add(3'd5, 32'h0, 32'h0, 32'h7770, 32'h0, 1'b0, 32'h7770, 0, 1'b1, 1'b0);
        add(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h7774, 0, 1'b0, 1'b0);
        // Simultaneous push and pop, non-empty and empty.
        add(3'd0, 32'h0, 32'h3600, 32'h0, 32'h0, 1'b1, 32'h7778, 1, 1'b0, 1'b0);
        add(3'd5, 32'h0, 32'h3700, 32'h3604, 32'h0, 1'b1, 32'h3604, 1, 1'b0, 1'b0);
        add(3'd5, 32'h0, 32'h0, 32'h3704, 32'h0, 1'b0, 32'h3704, 0, 1'b0, 1'b0);
        add(3'd5, 32'h0, 32'h3800, 32'h3900, 32'h0, 1'b1, 32'h3900, 1, 1'b1, 1'b0);
        add(3'd5, 32'h0, 32'h0, 32'h3804, 32'h0, 1'b0, 32'h3804, 0, 1'b0, 1'b0);
        add(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3808, 0, 1'b0, 1'b0);

        // Reset state.
        reset_n = 1'b0;
        stall   = 1'b0;
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        check_state("reset", 32'h3000, 0, 1'b0, 1'b0);
        check("reset pc_plus4", pc_plus4, 32'h3004);
        reset_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sel, vecs[i].instr, vecs[i].pc4, vecs[i].rs, vecs[i].rd, vecs[i].push);
            #1;
            check($sformatf("vec%0d npc", i), npc, vecs[i].exp_npc);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                        vecs[i].exp_uf, vecs[i].exp_miss);
        end

        // Stall: push once, then three stalled cycles asking for push and pop.
        drive(3'd0, 32'h0, 32'h3A00, 32'h0, 32'h0, 1'b1);
        step();
        check_state("pre-stall", 32'h380C, 1, 1'b0, 1'b0);
        pc_hold = 32'h380C;
        stall = 1'b1;
        drive(3'd5, 32'h0, 32'h3B00, 32'h3A04, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d npc", c), npc, 32'h3A04);
            step();
            check_state($sformatf("stall%0d", c), pc_hold, 1, 1'b0, 1'b0);
        end

        // Reset wins over stall.
        reset_n = 1'b0;
        step();
        check_state("reset-in-stall", 32'h3000, 0, 1'b0, 1'b0);
        #1;
        check("reset-in-stall empty npc", npc, 32'h3A04);
        reset_n = 1'b1;
        stall   = 1'b0;

        // Optional comparator: push 0x3028, pop with rs_data = 0x4000.
        drive(3'd0, 32'h0, 32'h3024, 32'h0, 32'h0, 1'b1);
        step();
        check_state("chk push", 32'h3004, 1, 1'b0, 1'b0);
        drive(3'd5, 32'h0, 32'h0, 32'h4000, 32'h0, 1'b0);
        #1;
        check("chk pop npc", npc, CHK ? 32'h4000 : 32'h3028);
        step();
        check_state("chk pop", CHK ? 32'h4000 : 32'h3028, 0, 1'b0, CHK);
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        check_state("chk after", CHK ? 32'h4004 : 32'h302C, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
